// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_LAT_MAX = 8;
  // Latency counter must hold MEM_LAT_MAX; starvation counter must hold 15.
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STARVE_W    = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive denied fetch-request cycles.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt_q;

  // Clear wins over increment; hold once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != STARVE_W'(STARVE_MAX))) begin
      cnt_q <= cnt_q + STARVE_W'(1);
    end
  end

  assign at_max = (cnt_q == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// One outstanding transaction, fixed memory latency tracked by a down-counter.
// Build option ARB_ROUND_ROBIN_EN: alternate priority on contention instead of
// fixed LS priority with an IF starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;
  logic             can_issue;
  logic             win_ls;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;
`else
  logic starve_max;

  // Fetch gets a guaranteed slot after STARVE_MAX consecutive denied cycles.
  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (if_req & ~if_gnt),
    .clr    (if_gnt | ~if_req),
    .at_max (starve_max)
  );
`endif

  // State, owner and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Completion, arbitration and memory-issue decode; everything quiet in reset.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    can_issue = 1'b0;
    win_ls    = 1'b0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif

    if (!rst) begin
      done      = (state_q == ARB_WAIT) && (cnt_q == CNT_W'(1));
      can_issue = (state_q == ARB_IDLE) || done;

      if (state_q == ARB_WAIT) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (done) begin
          state_d = ARB_IDLE;
        end
      end

      // Completion pulse for the current owner; stores return zero data.
      if (done) begin
        if (owner_q == OWN_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end else begin
          ls_rvalid = 1'b1;
          ls_rdata  = (op_q == OP_STORE) ? '0 : mem_rdata;
        end
      end

`ifdef ARB_ROUND_ROBIN_EN
      win_ls = ls_req && (!if_req || (last_q == OWN_IF));
`else
      win_ls = ls_req && !(if_req && starve_max);
`endif

      if (can_issue && (if_req || ls_req)) begin
        mem_en  = 1'b1;
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = ARB_WAIT;
        if (win_ls) begin
          ls_gnt    = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          owner_d   = OWN_LS;
          op_d      = ls_we ? OP_STORE : OP_LOAD;
        end else begin
          if_gnt    = 1'b1;
          mem_addr  = if_addr;
          owner_d   = OWN_IF;
          op_d      = OP_LOAD;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d = owner_d;
`endif
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction fetcher (IF) and the load/store path (LS) of the MIPS core.
- Allows at most one outstanding transaction and tracks fixed memory latency with a counter.
- Default policy: LS has fixed priority, with a starvation guard for IF.
- Sits between the Fetcher/LS logic and Memory; upstream stalls on missing grant.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from issue (mem_en=1) to valid mem_rdata; legal range 1..8
- STARVE_MAX, 4, consecutive denied IF-request cycles before IF wins; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse
- if_rvalid  out  1  one-cycle read-data-valid pulse
- if_rdata  out  DATA_W  fetch data, valid when if_rvalid
- ls_req  in  1  load/store request, held with payload until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle grant pulse
- ls_rvalid  out  1  completion pulse; loads and stores both complete
- ls_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  issue strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, cnt=0, owner=IF, starve_cnt=0.
  - All gnt, rvalid and mem_* outputs are 0 in the cycle after reset and while rst is held.
- FSM states: IDLE, WAIT.
- Issue is allowed ("can_issue") in IDLE, or in WAIT when cnt==1 (the completion cycle). This makes issue back-to-back with completion; with MEM_LAT=1, throughput is 1 transaction/cycle.
- Arbitration happens when can_issue and at least one request is high:
  - LS wins, unless if_req=1 and starve_cnt==STARVE_MAX, in which case IF wins.
  - The winner's gnt is asserted combinationally in the same cycle.
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the winner combinationally. For IF, mem_we=0 and mem_wdata=0.
- On a grant: owner<=winner, cnt<=MEM_LAT, state<=WAIT.
- In WAIT:
  - cnt decrements each cycle.
  - When cnt==1, the owner's rvalid=1 and rdata=mem_rdata (ls_rdata=0 for a store).
  - Next state is WAIT if a new grant issues this cycle, otherwise IDLE.
- Non-owner rvalid is always 0. rdata is 0 when its rvalid is 0.
- starve_cnt (saturating at STARVE_MAX):
  - increments on each cycle with if_req=1 and if_gnt=0;
  - clears on if_gnt or when if_req=0.
- IF may drop if_req before grant (branch redirect); this is legal and has no effect.
- LS must not drop ls_req before grant. If it does, it simply receives no grant; no error is raised.
- Simultaneous completion and new requests: completion rvalid and the new gnt occur in the same cycle. The new owner is latched, and the old owner's rvalid is unaffected.
- Reset mid-transaction: the outstanding transaction is abandoned and no rvalid is emitted. A store already issued to memory stands.
- Fixed latency: no backpressure from memory. mem_rdata is sampled only in the completion cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Priority alternates. A 1-bit last_winner register (reset=IF) makes the other requester win a contended arbitration.
  - Uncontended requests win immediately.
  - starve_cnt logic and STARVE_MAX are absent or ignored.
- Undefined: fixed LS priority with the starvation guard, as above.

Decomposition:
- Package ArbType:
  - owner_t enum {OWN_IF, OWN_LS}
  - arb_state_t enum {ARB_IDLE, ARB_WAIT}
  - constant MEM_LAT_MAX=8
- Widths reuse addr_t and op_t from Types.
- One sub-module, arb_starve_counter:
  - saturating counter with inc, clr and max-reached output, parameter STARVE_MAX;
  - instantiated only when ARB_ROUND_ROBIN_EN is undefined.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x0040_0000 at t0 -> if_gnt=1 and mem_en=1 at t0; if_rvalid=1 with if_rdata=mem_rdata at t1; idle at t2.
- Contention: if_req=ls_req=1, ls_we=1, ls_addr=0x1000_0010, ls_wdata=0xDEAD_BEEF -> ls_gnt at t0 with mem_we=1, mem_wdata=0xDEAD_BEEF; ls_rvalid with ls_rdata=0 at t1; if_gnt at t1 (back-to-back).
- Starvation, STARVE_MAX=4, MEM_LAT=1: ls_req held high with new loads, if_req high -> IF is denied 4 cycles and if_gnt is asserted on the 5th arbitration; starve_cnt then clears.
- MEM_LAT=3: one LS load -> ls_rvalid exactly 3 cycles after ls_gnt; no grant is issued in the 2 intervening cycles despite if_req=1; if_gnt coincides with ls_rvalid.
- Reset mid-op, MEM_LAT=3: grant at t0, rst=1 at t1 -> no rvalid at t3; all outputs 0 from t2; a fresh request after reset is granted normally.
- ARB_ROUND_ROBIN_EN defined: both requests held for 4 arbitrations -> grants in order LS, IF, LS, IF.
